boot_sequencer: RTL and testbench

Sequencer that boots the tiny processor on the FPGA demo board: on a start request it puts the processor in LOAD mode and shifts a program image from a small ROM into the processor's serial input, word by word, with a per-word acknowledge. It then switches the processor to RUN and reports completion when the processor signals done. It sits between the board switches/ROM and the processor's `uio_in[1:0]` (mode), `uio_in[4]` (serial data) and `uio_out[2]` (done) pins.

---
 rtl/boot_seq_pkg.sv | 26 ++
 rtl/boot_serializer.sv | 52 +++++
 rtl/boot_sequencer.sv | 160 ++++++++++++++++
 tb/tb_boot_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the processor boot sequencer.
// The state encoding is fixed 3-bit so it stays compatible with older
// register dumps and debug probes that decode the raw state value.
package boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } boot_state_e;

    // Processor mode pin encoding; 2'b11 is never driven.
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_RUN  = 2'b10;

    // Address width for a program of the given length (at least one bit).
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/boot_serializer.sv
// Byte-to-serial converter for the boot sequencer: loads one program word,
// then presents it MSB first, each bit held for BIT_DIV cycles while enabled.
// last_bit_done pulses in the final cycle of the eighth bit.
module boot_serializer #(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift_en,
    input  logic [7:0] byte_in,
    output logic       serial_out,
    output logic       last_bit_done
);

    localparam int              DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    logic [7:0]       shreg;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic             bit_end;

    assign bit_end       = shift_en && (div_cnt == DIV_LAST);
    assign last_bit_done = bit_end && (bit_cnt == 3'd7);
    assign serial_out    = shreg[7];

    // Shift register: capture the word on load, shift left at each bit boundary.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= byte_in;
        end else if (bit_end) begin
            shreg <= {shreg[6:0], 1'b0};
        end
    end

    // Divide and bit counters: restart with every new word.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer for the demo-board processor: on start, switches the
// processor to LOAD, streams PROG_WORDS ROM words serially with a per-word
// done/ack handshake, then switches to RUN and reports completion.
// Optional macro BOOT_SEQ_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on the
// ACK and RUN waits that ends in the ERR state.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int PROG_WORDS  = 16,
    parameter int BIT_DIV     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_in,
    input  logic                               done_in,
    input  logic [7:0]                         rom_data_in,
    output logic [addr_width(PROG_WORDS)-1:0]  rom_addr_out,
    output logic [1:0]                         mode_out,
    output logic                               mosi_out,
    output logic                               busy_out,
    output logic                               done_out,
    output logic                               err_out
);

    localparam int                ADDR_W    = addr_width(PROG_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_WORDS - 1);

    if (PROG_WORDS < 1 || PROG_WORDS > 256 || BIT_DIV < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("boot_sequencer: parameter out of range");
    end

    boot_state_e       state;
    boot_state_e       state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              done_q;
    logic              done_edge;
    logic              ser_bit;
    logic              last_bit_done;
    logic              wait_expired;
    logic              restart;

    // A level already high before the wait does not count; only a fresh rise does.
    assign done_edge = done_in & ~done_q;
    assign restart   = ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR)) && start_in;

    boot_serializer #(
        .BIT_DIV(BIT_DIV)
    ) u_ser (
        .clk          (clk),
        .rst          (rst),
        .load         (state == ST_FETCH),
        .shift_en     (state == ST_SHIFT),
        .byte_in      (rom_data_in),
        .serial_out   (ser_bit),
        .last_bit_done(last_bit_done)
    );

    // Registered copy of done_in for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_in;
        end
    end

`ifdef BOOT_SEQ_TIMEOUT_EN
    localparam int               WAIT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Watchdog: restarts on every state change, counts cycles spent in ACK or RUN.
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state)) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACK) || (state == ST_RUN)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_expired = ((state == ST_ACK) || (state == ST_RUN)) && (wait_cnt == WAIT_LAST);
    assign err_out      = (state == ST_ERR);
`else
    assign wait_expired = 1'b0;
    assign err_out      = 1'b0;
`endif

    // Next-state logic; a done edge takes priority over an expiring watchdog.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_in) state_nxt = ST_FETCH;
            end
            ST_FETCH: state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit_done) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (done_edge) begin
                    state_nxt = (addr == LAST_ADDR) ? ST_RUN : ST_FETCH;
                end else if (wait_expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RUN: begin
                if (done_edge) begin
                    state_nxt = ST_DONE;
                end else if (wait_expired) begin
                    state_nxt = ST_ERR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Word address: zero on every (re)start, advances after each acknowledged
    // word except the last, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            addr <= '0;
        end else if ((state == ST_ACK) && done_edge && (addr != LAST_ADDR)) begin
            addr <= addr + 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        mode_out = MODE_IDLE;
        busy_out = 1'b0;
        done_out = 1'b0;
        unique case (state)
            ST_FETCH, ST_SHIFT, ST_ACK: begin
                mode_out = MODE_LOAD;
                busy_out = 1'b1;
            end
            ST_RUN: begin
                mode_out = MODE_RUN;
                busy_out = 1'b1;
            end
            ST_DONE: done_out = 1'b1;
            default: ;
        endcase
    end

    assign mosi_out     = (state == ST_SHIFT) && ser_bit;
    assign rom_addr_out = addr;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: a two-word instance checked every cycle against a
// procedural timeline model, plus a one-word, BIT_DIV=1 instance checked with
// hand-computed literals. Timeout checks are active with BOOT_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_boot_sequencer;

    localparam int PW_A = 2;
    localparam int BD_A = 2;
    localparam int TO_A = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: two words, two cycles per bit
    logic       rst_a, start_a, done_a;
    logic [7:0] rom_data_a;
    logic [0:0] rom_addr_a;
    logic [1:0] mode_a;
    logic       mosi_a, busy_a, dout_a, err_a;
    logic [7:0] rom_a [PW_A] = '{8'hA5, 8'h3C};
    assign rom_data_a = rom_a[rom_addr_a];

    // Instance B: one word, one cycle per bit
    logic       rst_b, start_b, done_b;
    logic [7:0] rom_data_b;
    logic [0:0] rom_addr_b;
    logic [1:0] mode_b;
    logic       mosi_b, busy_b, dout_b, err_b;
    assign rom_data_b = 8'hB1;

    boot_sequencer #(.PROG_WORDS(PW_A), .BIT_DIV(BD_A), .TIMEOUT_CYC(TO_A)) dut_a (
        .clk(clk), .rst(rst_a), .start_in(start_a), .done_in(done_a),
        .rom_data_in(rom_data_a), .rom_addr_out(rom_addr_a), .mode_out(mode_a),
        .mosi_out(mosi_a), .busy_out(busy_a), .done_out(dout_a), .err_out(err_a)
    );

    boot_sequencer #(.PROG_WORDS(1), .BIT_DIV(1), .TIMEOUT_CYC(TO_A)) dut_b (
        .clk(clk), .rst(rst_b), .start_in(start_b), .done_in(done_b),
        .rom_data_in(rom_data_b), .rom_addr_out(rom_addr_b), .mode_out(mode_b),
        .mosi_out(mosi_b), .busy_out(busy_b), .done_out(dout_b), .err_out(err_b)
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_asrt++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- Timeline model of instance A ----------------
    int m_mode, m_mosi, m_busy, m_done, m_err, m_addr;
    bit m_ready = 1'b0;
    bit m_prev  = 1'b0;
    bit s_rst, s_start, s_edge;

    function automatic void m_set(int mode, int mosi, int busy, int dn, int er, int addr);
        m_mode = mode; m_mosi = mosi; m_busy = busy; m_done = dn; m_err = er; m_addr = addr;
    endfunction

    function automatic void m_idle();
        m_set(0, 0, 0, 0, 0, 0);
    endfunction

    // Close the current cycle: sample what the inputs were during it.
    task automatic m_step();
        @(posedge clk);
        s_rst   = rst_a;
        s_start = start_a;
        s_edge  = done_a && !m_prev;
        m_prev  = rst_a ? 1'b0 : done_a;
    endtask

    // One complete boot starting with the FETCH cycle of word 0.
    task automatic m_boot();
        int t;
        for (int w = 0; w < PW_A; w++) begin
            m_set(1, 0, 1, 0, 0, w);
            m_step();
            if (s_rst) begin m_idle(); return; end
            for (int b = 7; b >= 0; b--) begin
                for (int k = 0; k < BD_A; k++) begin
                    m_set(1, int'(rom_a[w][b]), 1, 0, 0, w);
                    m_step();
                    if (s_rst) begin m_idle(); return; end
                end
            end
            m_set(1, 0, 1, 0, 0, w);
            t = 0;
            forever begin
                m_step();
                if (s_rst) begin m_idle(); return; end
                if (s_edge) break;
`ifdef BOOT_SEQ_TIMEOUT_EN
                if (t == TO_A - 1) begin m_set(0, 0, 0, 0, 1, w); return; end
`endif
                t++;
            end
        end
        m_set(2, 0, 1, 0, 0, PW_A - 1);
        t = 0;
        forever begin
            m_step();
            if (s_rst) begin m_idle(); return; end
            if (s_edge) break;
`ifdef BOOT_SEQ_TIMEOUT_EN
            if (t == TO_A - 1) begin m_set(0, 0, 0, 0, 1, PW_A - 1); return; end
`endif
            t++;
        end
        m_set(0, 0, 0, 1, 0, PW_A - 1);
    endtask

    initial begin
        m_idle();
        forever begin
            m_step();
            if (s_rst) begin
                m_idle();
                m_ready = 1'b1;
            end else if (s_start) begin
                m_boot();
            end
        end
    end

    // Every-cycle comparison of instance A against the model
    always @(negedge clk) begin
        if (m_ready) begin
            chk("mdl_mode", int'(mode_a), m_mode);
            chk("mdl_mosi", int'(mosi_a), m_mosi);
            chk("mdl_busy", int'(busy_a), m_busy);
            chk("mdl_done", int'(dout_a), m_done);
            chk("mdl_err",  int'(err_a),  m_err);
            chk("mdl_addr", int'(rom_addr_a), m_addr);
        end
    end

    // Address trace while busy
    bit rec_en = 1'b0;
    int addr_q[$];
    always @(negedge clk) begin
        if (rec_en && busy_a) begin
            if (addr_q.size() == 0 || addr_q[$] != int'(rom_addr_a)) addr_q.push_back(int'(rom_addr_a));
        end
    end

    logic [7:0] cap [PW_A];

    // Full load of instance A with done pulses ack_dly cycles into each ACK
    // and run_dly cycles into RUN; captures the first cycle of every bit.
    task automatic run_load(input int ack_dly, input int run_dly, input bit hold, input bit glitch);
        @(negedge clk); start_a = 1'b1;
        for (int w = 0; w < PW_A; w++) begin
            @(negedge clk);
            done_a = 1'b0;
            if (!hold) start_a = 1'b0;
            chk("fetch_mode", int'(mode_a), 1);
            chk("fetch_addr", int'(rom_addr_a), w);
            cap[w] = '0;
            for (int k = 0; k < 8 * BD_A; k++) begin
                @(negedge clk);
                if (glitch && k == 5) done_a = 1'b1;
                if (glitch && k == 6) done_a = 1'b0;
                if (k % BD_A == 0) cap[w] = {cap[w][6:0], mosi_a};
            end
            repeat (ack_dly) @(negedge clk);
            @(negedge clk); done_a = 1'b1;
        end
        @(negedge clk); done_a = 1'b0; start_a = 1'b0;
        chk("run_mode", int'(mode_a), 2);
        chk("run_busy", int'(busy_a), 1);
        repeat (run_dly - 1) @(negedge clk);
        @(negedge clk); done_a = 1'b1;
        @(negedge clk); done_a = 1'b0;
        chk("done_flag", int'(dout_a), 1);
        chk("done_mode", int'(mode_a), 0);
        chk("done_busy", int'(busy_a), 0);
    endtask

    logic [7:0] exp_b;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; done_a = 1'b0; start_b = 1'b0; done_b = 1'b0;
        exp_b = 8'hB1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state
        chk("rst_mode_a", int'(mode_a), 0);
        chk("rst_mosi_a", int'(mosi_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_done_a", int'(dout_a), 0);
        chk("rst_err_a",  int'(err_a),  0);
        chk("rst_addr_a", int'(rom_addr_a), 0);
        chk("rst_mode_b", int'(mode_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);

        // Basic load
        run_load(3, 5, 1'b0, 1'b0);
        chk("basic_word0", int'(cap[0]), 'hA5);
        chk("basic_word1", int'(cap[1]), 'h3C);

        // Start held high through the load, done glitch during SHIFT
        addr_q.delete();
        rec_en = 1'b1;
        run_load(3, 5, 1'b1, 1'b1);
        rec_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_addr_cnt", addr_q.size(), 2);
        chk("hold_addr0", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
        chk("hold_addr1", (addr_q.size() > 1) ? addr_q[1] : -1, 1);
        chk("hold_word0", int'(cap[0]), 'hA5);
        chk("hold_stays_done", int'(dout_a), 1);

        // Reset in the 5th SHIFT cycle
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        chk("midrst_mode", int'(mode_a), 0);
        chk("midrst_mosi", int'(mosi_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_addr", int'(rom_addr_a), 0);
        run_load(3, 5, 1'b0, 1'b0);
        chk("reload_word0", int'(cap[0]), 'hA5);
        chk("reload_word1", int'(cap[1]), 'h3C);

        // Stale done level
        @(negedge clk); done_a = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (8 * BD_A) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("stale_mode", int'(mode_a), 1);
        chk("stale_mosi", int'(mosi_a), 0);
        chk("stale_addr", int'(rom_addr_a), 0);
        @(negedge clk); done_a = 1'b0;
        @(negedge clk); done_a = 1'b1;
        @(negedge clk);
        chk("stale_adv_addr", int'(rom_addr_a), 1);
        chk("stale_adv_mode", int'(mode_a), 1);
        done_a = 1'b0; rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;

`ifdef BOOT_SEQ_TIMEOUT_EN
        // Timeout in ACK: entered 18 cycles after start, ERR 16 cycles later
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (8 * BD_A) @(negedge clk);
        repeat (TO_A) @(negedge clk);
        chk("to_before_err",  int'(err_a),  0);
        chk("to_before_mode", int'(mode_a), 1);
        @(negedge clk);
        chk("to_err",  int'(err_a),  1);
        chk("to_mode", int'(mode_a), 0);
        chk("to_busy", int'(busy_a), 0);
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        chk("to_restart_mode", int'(mode_a), 1);
        chk("to_restart_err",  int'(err_a),  0);
        chk("to_restart_addr", int'(rom_addr_a), 0);
        rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
`endif

        // Minimum program on instance B: ROM 0xB1, one cycle per bit
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        chk("min_c1_mode", int'(mode_b), 1);
        chk("min_c1_mosi", int'(mosi_b), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("min_bit", int'(mosi_b), int'(exp_b[7 - i]));
        end
        @(negedge clk);
        chk("min_c10_mosi", int'(mosi_b), 0);
        chk("min_c10_mode", int'(mode_b), 1);
        chk("min_c10_busy", int'(busy_b), 1);
        done_b = 1'b1;
        @(negedge clk); done_b = 1'b0;
        chk("min_c11_run", int'(mode_b), 2);
        repeat (2) @(negedge clk);
        done_b = 1'b1;
        @(negedge clk); done_b = 1'b0;
        chk("min_done", int'(dout_b), 1);
        chk("min_done_mode", int'(mode_b), 0);
        chk("min_done_busy", int'(busy_b), 0);
        chk("min_err", int'(err_b), 0);
        chk("min_addr", int'(rom_addr_b), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
